// File: rtl/trap_csr_if.sv
// ----------------------------------------------------------------------------
// trap_csr_if
// Request/response bundle between the pipeline and the machine-mode trap/CSR
// unit.
//   exc_*      : exception request (valid, cause, faulting pc, trap value)
//   mret_valid : MRET retiring
//   csr_*      : CSR access request (valid, op, addr, wdata) and its response
//                (done, rdata, illegal)
//   redirect_* : fetch redirect handshake, plus a one-cycle pipeline flush
// modport master : pipeline side (drives requests, consumes responses)
// modport slave  : trap/CSR unit side
// ----------------------------------------------------------------------------
`ifndef XLEN
`define XLEN 32
`endif

interface trap_csr_if;
    logic              exc_valid;
    logic              exc_ready;
    logic [4:0]        exc_cause;
    logic [`XLEN-1:0]  exc_pc;
    logic [`XLEN-1:0]  exc_tval;
    logic              mret_valid;
    logic              csr_valid;
    logic [1:0]        csr_op;
    logic [11:0]       csr_addr;
    logic [`XLEN-1:0]  csr_wdata;
    logic              csr_done;
    logic [`XLEN-1:0]  csr_rdata;
    logic              csr_illegal;
    logic              redirect_valid;
    logic [`XLEN-1:0]  redirect_pc;
    logic              redirect_ready;
    logic              flush;

    modport master (
        output exc_valid, exc_cause, exc_pc, exc_tval, mret_valid,
               csr_valid, csr_op, csr_addr, csr_wdata, redirect_ready,
        input  exc_ready, csr_done, csr_rdata, csr_illegal,
               redirect_valid, redirect_pc, flush
    );

    modport slave (
        input  exc_valid, exc_cause, exc_pc, exc_tval, mret_valid,
               csr_valid, csr_op, csr_addr, csr_wdata, redirect_ready,
        output exc_ready, csr_done, csr_rdata, csr_illegal,
               redirect_valid, redirect_pc, flush
    );
endinterface

// File: rtl/trap_csr_unit.sv
// ----------------------------------------------------------------------------
// trap_csr_unit
// Machine-mode trap entry / MRET redirect plus the four trap CSRs
// (mtvec 0x305, mepc 0x341, mcause 0x342, mtval 0x343), direct mode only.
// Ports:
//   clk  : core clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : trap_csr_if.slave (exception / MRET / CSR requests, redirect out)
// Parameters:
//   RESET_MTVEC : reset value of mtvec (low two bits are dropped)
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | accepting exc / mret / csr requests (exc_ready=1)
//   REDIRECT | redirect_valid held, waiting for redirect_ready
// ----------------------------------------------------------------------------
`ifndef XLEN
`define XLEN 32
`endif

module trap_csr_unit #(
    parameter logic [`XLEN-1:0] RESET_MTVEC = '0
) (
    input  logic       clk,
    input  logic       rst,
    trap_csr_if.slave  bus
);
    typedef enum logic {IDLE = 1'b0, REDIRECT = 1'b1} state_t;

    localparam logic [1:0]  OP_W = 2'b01;
    localparam logic [1:0]  OP_S = 2'b10;
    localparam logic [1:0]  OP_C = 2'b11;
    localparam logic [11:0] A_MTVEC  = 12'h305;
    localparam logic [11:0] A_MEPC   = 12'h341;
    localparam logic [11:0] A_MCAUSE = 12'h342;
    localparam logic [11:0] A_MTVAL  = 12'h343;
    localparam logic [`XLEN-1:0] MTVEC_RST = {RESET_MTVEC[`XLEN-1:2], 2'b00};

    state_t           r_state;
    logic [`XLEN-1:0] r_mtvec, r_mepc, r_mcause, r_mtval;
    logic             r_csr_done, r_csr_illegal, r_redirect_valid, r_flush;
    logic [`XLEN-1:0] r_csr_rdata, r_redirect_pc;

    logic [`XLEN-1:0] w_old, w_new;
    logic             w_impl, w_ro_space, w_write, w_illegal;

    always_comb begin
        w_old  = '0;
        w_impl = 1'b1;
        case (bus.csr_addr)
            A_MTVEC:  w_old = r_mtvec;
            A_MEPC:   w_old = r_mepc;
            A_MCAUSE: w_old = r_mcause;
            A_MTVAL:  w_old = r_mtval;
            default:  w_impl = 1'b0;
        endcase
    end

    // The read-only window (addr[11:10]==11) reads as zero so that probing
    // ID registers with a non-writing access is not a trap; any write-class
    // access there is illegal. Everything else outside the four CSRs is illegal.
    assign w_ro_space = (bus.csr_addr[11:10] == 2'b11);
    assign w_write    = (bus.csr_op == OP_W) ||
                        (((bus.csr_op == OP_S) || (bus.csr_op == OP_C)) &&
                         (bus.csr_wdata != '0));
    assign w_illegal  = (!w_impl && !w_ro_space) || (w_ro_space && w_write);

    always_comb begin
        case (bus.csr_op)
            OP_W:    w_new = bus.csr_wdata;
            OP_S:    w_new = w_old | bus.csr_wdata;
            OP_C:    w_new = w_old & ~bus.csr_wdata;
            default: w_new = w_old;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state          <= IDLE;
            r_mtvec          <= MTVEC_RST;
            r_mepc           <= '0;
            r_mcause         <= '0;
            r_mtval          <= '0;
            r_csr_done       <= 1'b0;
            r_csr_illegal    <= 1'b0;
            r_csr_rdata      <= '0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_flush          <= 1'b0;
        end else begin
            r_flush       <= 1'b0;
            r_csr_done    <= 1'b0;
            r_csr_illegal <= 1'b0;
            r_csr_rdata   <= '0;
            case (r_state)
                IDLE: begin
                    if (bus.exc_valid) begin
                        r_mepc           <= {bus.exc_pc[`XLEN-1:2], 2'b00};
                        r_mcause         <= {{(`XLEN-5){1'b0}}, bus.exc_cause};
                        r_mtval          <= bus.exc_tval;
                        r_redirect_pc    <= {r_mtvec[`XLEN-1:2], 2'b00};
                        r_redirect_valid <= 1'b1;
                        r_flush          <= 1'b1;
                        r_state          <= REDIRECT;
                    end else if (bus.mret_valid) begin
                        r_redirect_pc    <= r_mepc;
                        r_redirect_valid <= 1'b1;
                        r_flush          <= 1'b1;
                        r_state          <= REDIRECT;
                    end else if (bus.csr_valid) begin
                        r_csr_done    <= 1'b1;
                        r_csr_illegal <= w_illegal;
                        r_csr_rdata   <= w_illegal ? '0 : w_old;
                        if (!w_illegal && w_write) begin
                            case (bus.csr_addr)
                                A_MTVEC:  r_mtvec  <= {w_new[`XLEN-1:2], 2'b00};
                                A_MEPC:   r_mepc   <= {w_new[`XLEN-1:2], 2'b00};
                                A_MCAUSE: r_mcause <= w_new;
                                A_MTVAL:  r_mtval  <= w_new;
                                default:  ;
                            endcase
                        end
                    end
                end
                REDIRECT: begin
                    if (bus.redirect_ready) begin
                        r_redirect_valid <= 1'b0;
                        r_state          <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.exc_ready      = (r_state == IDLE);
    assign bus.csr_done       = r_csr_done;
    assign bus.csr_illegal    = r_csr_illegal;
    assign bus.csr_rdata      = r_csr_rdata;
    assign bus.redirect_valid = r_redirect_valid;
    assign bus.redirect_pc    = r_redirect_pc;
    assign bus.flush          = r_flush;
endmodule
